// File: rtl/aes_key_sched.sv
// aes_key_sched -- word-serial AES-128 key expansion engine.
//
// Takes a 128-bit cipher key on a kLoad pulse and expands it one 32-bit
// word per clock into a 44-word (11 round key) buffer. Once all keys are
// valid, it serves the round key for the requested round index with one
// cycle of registered latency. The order is forward for encryption and
// reverse for decryption.
//
// Ports:
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   kLoad    one-cycle pulse: sample key, (re)start expansion
//   key      cipher key, bits [127:96] = w0
//   ed       1 = encrypt (forward order), 0 = decrypt (reverse order)
//   rcRound  requested round index 0..NR
//   kBusy    expansion in progress
//   kReady   all NR+1 round keys valid
//   rKey     registered round key for the requested round (0 when invalid)
module aes_key_sched #(
    parameter int NR     = 10,
    parameter int RKEY_W = 128
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              kLoad,
    input  logic [RKEY_W-1:0] key,
    input  logic              ed,
    input  logic [3:0]        rcRound,
    output logic              kBusy,
    output logic              kReady,
    output logic [RKEY_W-1:0] rKey
);

    localparam int         NWORDS  = 4 * (NR + 1);
    localparam logic [5:0] LAST_W  = 6'(NWORDS - 1);
    localparam logic [3:0] NR4     = 4'(NR);

    // Forward S-box, byte 0x00 in the top byte of row 0.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // Byte b sits at bits [2047-8b -: 8]; 2047-8b == {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        logic [7:0] r;
        case (j)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [31:0] w [NWORDS];
    logic [31:0] temp;
    logic [31:0] w_new;
    logic [3:0]  rsel;
    logic [5:0]  rbase;

    // Next-state and counter logic. A new kLoad always restarts expansion.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (kLoad) begin
            state_nxt = EXPAND;
            cnt_nxt   = 6'd4;
        end else begin
            case (state)
                EXPAND: begin
                    if (cnt == LAST_W) begin
                        state_nxt = READY;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word recurrence: w[i] = w[i-4] ^ f(w[i-1]); f applies on i mod 4 == 0.
    always_comb begin
        temp = w[cnt - 6'd1];
        if (cnt[1:0] == 2'b00) begin
            temp = sub_word(rot_word(temp)) ^ {rcon(cnt[5:2]), 24'h0};
        end
        w_new = w[cnt - 6'd4] ^ temp;
    end

    // Decrypt walks the schedule from the last round key backwards.
    always_comb begin
        rsel  = ed ? rcRound : (NR4 - rcRound);
        rbase = {rsel, 2'b00};
    end

    // Control state and served key; reset brings everything to a known idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 6'd0;
            rKey  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == READY && !kLoad && rcRound <= NR4) begin
                rKey <= {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};
            end else begin
                rKey <= '0;
            end
        end
    end

    // Key buffer is not reset; kReady gates any use of its contents.
    always_ff @(posedge CLK) begin
        if (kLoad) begin
            w[0] <= key[127:96];
            w[1] <= key[95:64];
            w[2] <= key[63:32];
            w[3] <= key[31:0];
        end else if (state == EXPAND) begin
            w[cnt] <= w_new;
        end
    end

    assign kBusy  = (state == EXPAND);
    assign kReady = (state == READY);

endmodule

// File: tb/tb_aes_key_sched.sv
// Testbench for aes_key_sched: FIPS-197 and all-zero key schedules,
// load-to-ready latency, reload and reset during expansion, and
// out-of-range round requests. Expected round keys go into a queue when
// a request is driven and are popped when the registered key appears.
module tb_aes_key_sched;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         CLK;
    logic         RST;
    logic         kLoad;
    logic [127:0] key;
    logic         ed;
    logic [3:0]   rcRound;
    logic         kBusy;
    logic         kReady;
    logic [127:0] rKey;

    int total = 0;
    int bad   = 0;
    logic [127:0] sb_q [$];

    aes_key_sched #(.NR(10), .RKEY_W(128)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .kLoad   (kLoad),
        .key     (key),
        .ed      (ed),
        .rcRound (rcRound),
        .kBusy   (kBusy),
        .kReady  (kReady),
        .rKey    (rKey)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [127:0] k);
        key   = k;
        kLoad = 1'b1;
        step();
        kLoad = 1'b0;
    endtask

    // Counts edges from the kLoad edge until kReady, bounded.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!kReady && n < 100) begin
            step();
            n++;
        end
        chk(tag, 128'(n), 128'd40);
    endtask

    task automatic req(input string tag, input logic e, input logic [3:0] rc, input logic [127:0] exp);
        ed      = e;
        rcRound = rc;
        sb_q.push_back(exp);
        step();
        chk(tag, rKey, sb_q.pop_front());
    endtask

    initial begin
        int seen;
        RST     = 1'b1;
        kLoad   = 1'b0;
        key     = '0;
        ed      = 1'b1;
        rcRound = 4'd0;
        repeat (3) step();
        chk("rst_busy",  128'(kBusy),  128'd0);
        chk("rst_ready", 128'(kReady), 128'd0);
        chk("rst_rkey",  rKey,         128'd0);
        RST = 1'b0;
        step();

        // FIPS-197 key
        do_load(KEY_FIPS);
        chk("fips_busy", 128'(kBusy), 128'd1);
        chk("exp_rkey0", rKey, 128'd0);
        wait_ready("fips_lat");
        chk("fips_busy_done", 128'(kBusy), 128'd0);
        req("fips_e1",  1'b1, 4'd1,  FIPS_R1);
        req("fips_e10", 1'b1, 4'd10, FIPS_R10);
        req("fips_d0",  1'b0, 4'd0,  FIPS_R10);
        req("fips_d10", 1'b0, 4'd10, KEY_FIPS);
        req("fips_d9",  1'b0, 4'd9,  FIPS_R1);
        req("fips_e0",  1'b1, 4'd0,  KEY_FIPS);
        req("fips_e11", 1'b1, 4'd11, 128'd0);

        // All-zero key, reloaded from READY
        do_load(KEY_ZERO);
        chk("reload_ready_drop", 128'(kReady), 128'd0);
        wait_ready("zero_lat");
        req("zero_e1",  1'b1, 4'd1,  ZERO_R1);
        req("zero_e10", 1'b1, 4'd10, ZERO_R10);
        req("zero_d0",  1'b0, 4'd0,  ZERO_R10);

        // Reload mid-expansion: second kLoad lands 15 cycles after the first
        do_load(KEY_ZERO);
        repeat (14) step();
        chk("mid_busy", 128'(kBusy), 128'd1);
        do_load(KEY_FIPS);
        wait_ready("reload_lat");
        req("reload_e1", 1'b1, 4'd1, FIPS_R1);

        // Reset mid-expansion: RST lands 20 cycles after kLoad
        do_load(KEY_ZERO);
        repeat (19) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rstmid_busy",  128'(kBusy),  128'd0);
        chk("rstmid_ready", 128'(kReady), 128'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (kReady || kBusy || rKey != 0) seen++;
        end
        chk("rstmid_quiet", 128'(seen), 128'd0);

        // kLoad together with RST: reset wins
        key   = KEY_FIPS;
        kLoad = 1'b1;
        RST   = 1'b1;
        step();
        kLoad = 1'b0;
        RST   = 1'b0;
        chk("rst_over_load", 128'(kBusy), 128'd0);

        do_load(KEY_FIPS);
        wait_ready("after_rst_lat");
        req("after_rst_e12", 1'b1, 4'd12, 128'd0);
        req("after_rst_d15", 1'b0, 4'd15, 128'd0);
        req("after_rst_e10", 1'b1, 4'd10, FIPS_R10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
